// File: rtl/srcnn_conv_mac.sv
// SRCNN convolution multiply-accumulate stage: a product register feeds an accumulator
// that rounds, shifts and saturates each TAPS-long window into one output sample.
module srcnn_conv_mac #(
    parameter int DIN_W  = 9,
    parameter int PROD_W = 2 * DIN_W,
    parameter int TAPS   = 9,
    parameter int ACC_W  = 22,
    parameter int SHIFT  = 8,
    parameter int DOUT_W = 9
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN_W-1:0]  in_pix,
    input  logic [DIN_W-1:0]  in_wt,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_W-1:0] out_data,
    output logic              out_sat,
    output logic              tap_err
);

    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TAPS - 1);
    localparam logic [ACC_W:0]   ROUND_C  = (ACC_W + 1)'(1) << (SHIFT - 1);
    localparam logic [ACC_W:0]   OUT_MAX  = (ACC_W + 1)'((1 << DOUT_W) - 1);

    logic [CNT_W-1:0]  tap_cnt_q, tap_cnt_d;
    logic              p_valid_q, p_valid_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]  p_idx_q, p_idx_d;
    logic              p_last_q, p_last_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              out_valid_q, out_valid_d;
    logic [DOUT_W-1:0] out_data_q, out_data_d;
    logic              out_sat_q, out_sat_d;
    logic              tap_err_q, tap_err_d;

    logic              stall;
    logic              accept;
    logic [ACC_W-1:0]  acc_sum;
    logic [ACC_W:0]    rounded;
    logic [ACC_W:0]    q_val;

    assign stall    = out_valid_q & ~out_ready;
    assign accept   = in_valid & ~stall;
    assign in_ready = ~stall;

    // Tap 0 restarts the window; the extra MSB keeps the rounding add from wrapping.
    assign acc_sum = (p_idx_q == '0) ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
    assign rounded = {1'b0, acc_sum} + ROUND_C;
    assign q_val   = rounded >> SHIFT;

    always_comb begin
        tap_cnt_d   = tap_cnt_q;
        p_valid_d   = p_valid_q;
        prod_d      = prod_q;
        p_idx_d     = p_idx_q;
        p_last_d    = p_last_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        tap_err_d   = tap_err_q;

        if (!stall) begin
            p_valid_d = accept;
            if (accept) begin
                prod_d    = PROD_W'(in_pix) * PROD_W'(in_wt);
                p_idx_d   = tap_cnt_q;
                p_last_d  = in_last;
                tap_cnt_d = (tap_cnt_q == LAST_IDX) ? '0 : tap_cnt_q + CNT_W'(1);
            end

            if (p_valid_q) begin
                acc_d = acc_sum;
                if (p_last_q != (p_idx_q == LAST_IDX)) begin
                    tap_err_d = 1'b1;
                end
            end

            // Without a stall any held result has just been taken, so it either
            // gets replaced by a closing window or drops.
            if (p_valid_q && (p_idx_q == LAST_IDX)) begin
                out_valid_d = 1'b1;
                if (q_val > OUT_MAX) begin
                    out_data_d = {DOUT_W{1'b1}};
                    out_sat_d  = 1'b1;
                end else begin
                    out_data_d = q_val[DOUT_W-1:0];
                    out_sat_d  = 1'b0;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            tap_cnt_q   <= '0;
            p_valid_q   <= 1'b0;
            prod_q      <= '0;
            p_idx_q     <= '0;
            p_last_q    <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            tap_err_q   <= 1'b0;
        end else begin
            tap_cnt_q   <= tap_cnt_d;
            p_valid_q   <= p_valid_d;
            prod_q      <= prod_d;
            p_idx_q     <= p_idx_d;
            p_last_q    <= p_last_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            tap_err_q   <= tap_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign tap_err   = tap_err_q;

endmodule

// File: tb/tb_srcnn_conv_mac.sv
// Bench for srcnn_conv_mac: directed and random windows compared against a plain
// arithmetic model of the window sum, rounding and saturation.
module tb_srcnn_conv_mac;

    localparam int DIN_W  = 9;
    localparam int TAPS   = 9;
    localparam int SHIFT  = 8;
    localparam int DOUT_W = 9;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic              in_valid;
    logic              in_ready;
    logic [DIN_W-1:0]  in_pix;
    logic [DIN_W-1:0]  in_wt;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DOUT_W-1:0] out_data;
    logic              out_sat;
    logic              tap_err;

    int compared   = 0;
    int mismatched = 0;
    int exp_q[$];
    int got_q[$];
    int win_pix[TAPS];
    int win_wt[TAPS];
    bit rand_bp = 1'b0;

    srcnn_conv_mac dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pix    (in_pix),
        .in_wt     (in_wt),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .tap_err   (tap_err)
    );

    always #5 ap_clk = ~ap_clk;

    // Results are encoded as {sat, data}; a transfer happens on the next rising edge.
    always @(negedge ap_clk) begin
        if (!ap_rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            got_q.push_back(int'({out_sat, out_data}));
        end
    end

    always @(posedge ap_clk) begin
        if (rand_bp) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic check_output(string tag, logic [31:0] observed, logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int model_window();
        longint sum = 0;
        longint q;
        for (int i = 0; i < TAPS; i++) sum += longint'(win_pix[i]) * longint'(win_wt[i]);
        q = (sum + (longint'(1) << (SHIFT - 1))) >> SHIFT;
        if (q > (1 << DOUT_W) - 1) return (1 << DOUT_W) | ((1 << DOUT_W) - 1);
        return int'(q);
    endfunction

    task automatic fill_const(int p, int w);
        for (int i = 0; i < TAPS; i++) begin
            win_pix[i] = p;
            win_wt[i]  = w;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < TAPS; i++) begin
            win_pix[i] = int'($urandom_range(0, (1 << DIN_W) - 1));
            win_wt[i]  = int'($urandom_range(0, (1 << DIN_W) - 1));
        end
    endtask

    // Entered and left just after a rising edge; returns right after the accepting edge.
    task automatic apply_stimulus(int pix, int wt, bit last, int gap);
        bit done = 1'b0;
        int n = 0;
        repeat (gap) begin
            @(posedge ap_clk);
            #1;
        end
        in_valid = 1'b1;
        in_pix   = DIN_W'(pix);
        in_wt    = DIN_W'(wt);
        in_last  = last;
        while (!done && n < 200) begin
            @(negedge ap_clk);
            done = (in_ready === 1'b1);
            @(posedge ap_clk);
            n++;
        end
        if (!done) check_output("accept_timeout", 32'd0, 32'd1);
        #1;
        in_valid = 1'b0;
        in_pix   = DIN_W'($urandom);
        in_wt    = DIN_W'($urandom);
        in_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic send_window(int bad_pos, int max_gap);
        exp_q.push_back(model_window());
        for (int i = 0; i < TAPS; i++) begin
            apply_stimulus(win_pix[i], win_wt[i], (i == TAPS - 1) || (i == bad_pos),
                           (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
    endtask

    task automatic drain_and_compare(string tag);
        int n = 0;
        int cnt;
        while ((got_q.size() < exp_q.size() || out_valid === 1'b1) && n < 300) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        check_output({tag, "_count"}, got_q.size(), exp_q.size());
        cnt = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < cnt; i++) begin
            check_output($sformatf("%s_result%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        in_pix    = '0;
        in_wt     = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_out_data", out_data, 0);
        check_output("rst_out_sat", out_sat, 0);
        check_output("rst_tap_err", tap_err, 0);
        check_output("rst_in_ready", in_ready, 1);

        // Unity window with a cycle-exact latency check.
        fill_const(16, 16);
        send_window(-1, 0);
        @(negedge ap_clk);
        check_output("lat_t1_valid", out_valid, 0);
        @(negedge ap_clk);
        check_output("lat_t2_valid", out_valid, 1);
        check_output("lat_t2_data", out_data, 9);
        check_output("lat_t2_sat", out_sat, 0);
        check_output("lat_t2_tap_err", tap_err, 0);
        @(posedge ap_clk);
        #1;
        drain_and_compare("win16");

        fill_const(1, 128);
        send_window(-1, 0);
        exp_q[0] = 5;
        drain_and_compare("round_half_up");

        fill_const(255, 255);
        send_window(-1, 0);
        exp_q[0] = (1 << DOUT_W) | 511;
        drain_and_compare("saturate");

        // Back-to-back windows with the first result held under backpressure.
        fork
            begin
                fill_const(16, 16);
                send_window(-1, 0);
                fill_const(1, 128);
                send_window(-1, 0);
            end
            begin
                int n = 0;
                while (out_valid !== 1'b1 && n < 100) begin
                    @(posedge ap_clk);
                    #1;
                    n++;
                end
                check_output("stall_first_seen", out_valid, 1);
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge ap_clk);
                    check_output("stall_in_ready", in_ready, 0);
                    check_output("stall_out_valid", out_valid, 1);
                    check_output("stall_out_data", out_data, 9);
                    @(posedge ap_clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain_and_compare("b2b");
        check_output("b2b_order_ok", compared > 0, 1);

        // Random operands with input bubbles and random output backpressure.
        rand_bp = 1'b1;
        repeat (4) begin
            fill_rand();
            send_window(-1, 2);
        end
        rand_bp = 1'b0;
        @(posedge ap_clk);
        #1;
        out_ready = 1'b1;
        drain_and_compare("random");
        check_output("random_tap_err", tap_err, 0);

        // Early in_last on beat 4 flags an error but the window still closes on beat 9.
        fill_rand();
        send_window(3, 0);
        drain_and_compare("early_last");
        check_output("tap_err_set", tap_err, 1);
        repeat (5) @(posedge ap_clk);
        #1;
        check_output("tap_err_sticky", tap_err, 1);

        // Reset mid-window discards the partial sum and clears the error flag.
        fill_rand();
        for (int i = 0; i < 5; i++) apply_stimulus(win_pix[i], win_wt[i], 1'b0, 0);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        check_output("midrst_out_valid", out_valid, 0);
        check_output("midrst_tap_err", tap_err, 0);
        got_q.delete();
        exp_q.delete();
        fill_const(16, 16);
        send_window(-1, 0);
        drain_and_compare("after_reset");
        check_output("after_reset_tap_err", tap_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/srcnn_conv_mac.md
Name: srcnn_conv_mac

Overview:
- Multiply-accumulate stage for SRCNN convolution windows.
- Consumes streamed unsigned pixel/weight pairs and forms 9x9-bit unsigned products internally.
- Accumulates one kernel window of TAPS products, then rounds, shifts and saturates the sum into one feature-map output sample.
- Sits directly downstream of the pixel/weight fetch logic and upstream of the feature-map writer; valid/ready on both sides.

Parameters:
- DIN_W, 9, width of pixel and weight operands (unsigned)
- PROD_W, 18, product width, equal to 2*DIN_W
- TAPS, 9, products per window (3x3 kernel)
- ACC_W, 22, accumulator width; must be at least PROD_W+ceil(log2(TAPS))
- SHIFT, 8, right shift applied to the rounded sum; must be at least 1
- DOUT_W, 9, output sample width (unsigned)

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept an operand pair
- in_pix  in  DIN_W  pixel operand
- in_wt  in  DIN_W  weight operand
- in_last  in  1  upstream marks final tap of a window
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  DOUT_W  rounded, shifted, saturated window sum
- out_sat  out  1  out_data was clamped; qualified by out_valid
- tap_err  out  1  sticky framing error flag

Behaviour:
- Reset (async assert; deassert sampled on ap_clk): out_valid=0, out_data=0, out_sat=0, tap_err=0, tap counter=0, accumulator=0, product-stage valid=0. Reset mid-window discards the partial sum.
- stall = out_valid & ~out_ready. in_ready = ~stall. Both internal stages hold while stall is high.
- Stage P (product): on accept (in_valid & in_ready), register prod = in_pix*in_wt (unsigned, PROD_W bits, no truncation), plus tap index and in_last.
- Stage A (accumulate): when P holds data and ~stall:
  - tap index 0: acc = prod.
  - otherwise: acc = acc + prod.
- Tap counter counts accepted beats from 0 to TAPS-1 and wraps to 0 after the TAPS-th beat. A window always closes on the TAPS-th beat.
- On the closing beat, in stage A:
  - sum = acc_final + 2^(SHIFT-1), computed without overflow at ACC_W+1 bits.
  - q = sum >> SHIFT (round half up).
  - If q > 2^DOUT_W-1: out_data = 2^DOUT_W-1 and out_sat = 1. Otherwise out_data = q and out_sat = 0.
  - out_valid is set to 1.
- Latency: closing beat accepted in cycle t gives out_valid=1 in cycle t+2.
- Throughput: one pair per cycle with no bubbles between consecutive windows.
- Output handshake:
  - out_data and out_sat hold stable while out_valid & ~out_ready.
  - out_valid & out_ready with a new closing beat in stage A in the same cycle: the new result loads and out_valid stays 1.
  - out_ready with nothing pending: out_valid clears.
- tap_err is set, and stays set until reset, when either:
  - in_last = 1 on a beat whose index is not TAPS-1, or
  - in_last = 0 on index TAPS-1.
  Data flow is unaffected by tap_err.
- in_valid low between taps inserts bubbles; the partial sum is preserved indefinitely.
- Values of in_pix and in_wt are ignored when in_valid = 0.

Test Plan:
- After reset, 9 beats with pix=16, wt=16, in_last only on beat 9, out_ready=1 -> one output 2 cycles after the last accept: out_data=9, out_sat=0, tap_err=0.
- 9 beats with pix=1, wt=128 -> sum 1152, rounded (1152+128)>>8 gives out_data=5 (half rounds up), out_sat=0.
- 9 beats with pix=255, wt=255 -> sum 585225 gives q=2286, so out_data=511, out_sat=1.
- Two back-to-back windows (pix=16/wt=16, then pix=1/wt=128) with out_ready held low 5 cycles after the first result:
  - in_ready drops while stalled.
  - out_data stays 9 during the stall.
  - Both results 9 then 5 are delivered, none lost or duplicated.
- in_last asserted on beat 4 -> tap_err=1 and stays 1; the window still closes on beat 9 with the correct sum.
- ap_rst pulsed after beat 5 of a window, then 9 fresh beats with pix=16, wt=16 -> single output 9; the partial sum from before reset has no effect.
